// File: rtl/uart_cmd_master.sv
// Host-side initiator for the UART command protocol: serializes one command
// into its byte frame over a TX handshake, then collects 0..2 response bytes
// from the receiver and reports them as one response word plus error status.
module uart_cmd_master #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_W           = 12
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [1:0]  CMD_TYPE,
   input  logic [3:0]  CMD_ADDR,
   input  logic [7:0]  CMD_WDATA,
   input  logic [7:0]  CMD_OPA,
   input  logic [7:0]  CMD_OPB,
   input  logic [3:0]  CMD_FUN,
   output logic [7:0]  TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   input  logic [7:0]  RX_DATA,
   input  logic        RX_VALID,
   input  logic        RX_PAR_ERR,
   input  logic        RX_FRM_ERR,
   output logic [15:0] RSP_DATA,
   output logic        RSP_VALID,
   output logic [1:0]  RSP_ERR,
   output logic        BUSY
);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, DONE} state_t;

   localparam logic [1:0]      T_WR   = 2'b00;
   localparam logic [1:0]      T_RD   = 2'b01;
   localparam logic [1:0]      T_ALU  = 2'b10;
   localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state_q, state_d;
   logic [1:0]      type_q;
   logic [3:0]      addr_q, fun_q;
   logic [7:0]      wdata_q, opa_q, opb_q;
   logic [1:0]      idx_q, idx_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic [15:0]     rsp_data_q, rsp_data_d;
   logic [1:0]      rsp_err_q, rsp_err_d;
   logic [7:0]      frame_byte;
   logic [1:0]      last_idx;
   logic            accept, rx_bad;

   assign accept = CMD_VALID && (state_q == IDLE);
   assign rx_bad = RX_PAR_ERR || RX_FRM_ERR;

   // Frame byte selected by the latched command type and the byte index.
   always_comb begin
      frame_byte = 8'h00;
      last_idx   = 2'd0;
      case (type_q)
         2'b00: begin
            last_idx = 2'd2;
            case (idx_q)
               2'd0:    frame_byte = 8'hAA;
               2'd1:    frame_byte = {4'h0, addr_q};
               default: frame_byte = wdata_q;
            endcase
         end
         2'b01: begin
            last_idx   = 2'd1;
            frame_byte = (idx_q == 2'd0) ? 8'hBB : {4'h0, addr_q};
         end
         2'b10: begin
            last_idx = 2'd3;
            case (idx_q)
               2'd0:    frame_byte = 8'hCC;
               2'd1:    frame_byte = opa_q;
               2'd2:    frame_byte = opb_q;
               default: frame_byte = {4'h0, fun_q};
            endcase
         end
         default: begin
            last_idx   = 2'd1;
            frame_byte = (idx_q == 2'd0) ? 8'hDD : {4'h0, fun_q};
         end
      endcase
   end

   // Next-state logic: frame sequencing, response capture, error/timeout.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (CMD_VALID) begin
               idx_d      = 2'd0;
               rsp_data_d = 16'h0000;
               rsp_err_d  = 2'b00;
               state_d    = SEND;
            end
         end
         SEND: begin
            if (TX_READY) begin
               if (idx_q == last_idx) begin
                  idx_d   = 2'd0;
                  cnt_d   = '0;
                  state_d = (type_q == T_WR) ? DONE : WAIT_LO;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         WAIT_LO: begin
            if (RX_VALID) begin
               if (rx_bad) begin
                  rsp_err_d[1] = 1'b1;
                  state_d      = DONE;
               end else begin
                  rsp_data_d[7:0] = RX_DATA;
                  cnt_d           = '0;
                  state_d         = (type_q == T_RD) ? DONE : WAIT_HI;
               end
            end else if (cnt_q == TO_END) begin
               rsp_err_d[0] = 1'b1;
               state_d      = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_HI: begin
            if (RX_VALID) begin
               if (rx_bad) rsp_err_d[1] = 1'b1;
               else        rsp_data_d[15:8] = RX_DATA;
               state_d = DONE;
            end else if (cnt_q == TO_END) begin
               rsp_err_d[0] = 1'b1;
               state_d      = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control and response state registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         cnt_q      <= '0;
         rsp_data_q <= 16'h0000;
         rsp_err_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Command fields captured on accept so the host may change inputs after.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         type_q  <= T_WR;
         addr_q  <= 4'h0;
         wdata_q <= 8'h00;
         opa_q   <= 8'h00;
         opb_q   <= 8'h00;
         fun_q   <= 4'h0;
      end else if (accept) begin
         type_q  <= CMD_TYPE;
         addr_q  <= CMD_ADDR;
         wdata_q <= CMD_WDATA;
         opa_q   <= CMD_OPA;
         opb_q   <= CMD_OPB;
         fun_q   <= CMD_FUN;
      end
   end

   // Outputs decode straight from registered state; TX_VALID therefore
   // drops as soon as the asynchronous reset clears the state register.
   assign CMD_READY = (state_q == IDLE);
   assign BUSY      = (state_q != IDLE);
   assign TX_VALID  = (state_q == SEND);
   assign TX_DATA   = (state_q == SEND) ? frame_byte : 8'h00;
   assign RSP_VALID = (state_q == DONE);
   assign RSP_DATA  = rsp_data_q;
   assign RSP_ERR   = rsp_err_q;

   // T_ALU documents the encoding; ALU op and nop share the response path.
   logic unused_ok;
   assign unused_ok = &{1'b0, T_ALU};

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master. A second instance with a short timeout
// exercises the timeout path; it shares every input except CMD_VALID.
module tb_uart_cmd_master;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        cmd_valid = 1'b0, cmd_valid16 = 1'b0;
   logic [1:0]  cmd_type = 2'b00;
   logic [3:0]  cmd_addr = 4'h0, cmd_fun = 4'h0;
   logic [7:0]  cmd_wdata = 8'h00, cmd_opa = 8'h00, cmd_opb = 8'h00;
   logic        tx_ready = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0, rx_par = 1'b0, rx_frm = 1'b0;

   logic        cmd_ready, tx_valid, rsp_valid, busy;
   logic [7:0]  tx_data;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_err;
   logic        cmd_ready16, tx_valid16, rsp_valid16, busy16;
   logic [7:0]  tx_data16;
   logic [15:0] rsp_data16;
   logic [1:0]  rsp_err16;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   uart_cmd_master dut (
      .CLK(CLK), .RST(RST), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
      .CMD_OPA(cmd_opa), .CMD_OPB(cmd_opb), .CMD_FUN(cmd_fun),
      .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
      .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_PAR_ERR(rx_par),
      .RX_FRM_ERR(rx_frm), .RSP_DATA(rsp_data), .RSP_VALID(rsp_valid),
      .RSP_ERR(rsp_err), .BUSY(busy)
   );

   uart_cmd_master #(.TIMEOUT_CYCLES(16), .TO_W(4)) dut16 (
      .CLK(CLK), .RST(RST), .CMD_VALID(cmd_valid16), .CMD_READY(cmd_ready16),
      .CMD_TYPE(cmd_type), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
      .CMD_OPA(cmd_opa), .CMD_OPB(cmd_opb), .CMD_FUN(cmd_fun),
      .TX_DATA(tx_data16), .TX_VALID(tx_valid16), .TX_READY(tx_ready),
      .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_PAR_ERR(rx_par),
      .RX_FRM_ERR(rx_frm), .RSP_DATA(rsp_data16), .RSP_VALID(rsp_valid16),
      .RSP_ERR(rsp_err16), .BUSY(busy16)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a command at a falling edge; returns at the next falling edge,
   // i.e. one cycle after the accepting rising edge.
   task automatic issue(input logic use16, input logic [1:0] t, input logic [3:0] a,
                        input logic [7:0] w, input logic [7:0] oa, input logic [7:0] ob,
                        input logic [3:0] f);
      cmd_type = t; cmd_addr = a; cmd_wdata = w; cmd_opa = oa; cmd_opb = ob; cmd_fun = f;
      if (use16) cmd_valid16 = 1'b1; else cmd_valid = 1'b1;
      @(negedge CLK);
      cmd_valid = 1'b0; cmd_valid16 = 1'b0;
      // Scramble fields: the DUT must use its latched copy.
      cmd_type = ~t; cmd_addr = ~a; cmd_wdata = ~w; cmd_opa = ~oa; cmd_opb = ~ob; cmd_fun = ~f;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] alu_bytes [4];
      logic       seen;
      alu_bytes[0] = 8'hCC; alu_bytes[1] = 8'h12; alu_bytes[2] = 8'h34; alu_bytes[3] = 8'h00;

      // Reset values
      repeat (2) @(negedge CLK);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      RST = 1'b1;
      @(negedge CLK);

      // WR addr=5 data=3C, back-to-back bytes
      tx_ready = 1'b1;
      issue(0, 2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
      chk("wr_busy", busy, 1);
      chk("wr_b0_valid", tx_valid, 1);
      chk("wr_b0", tx_data, 16'h00AA);
      @(negedge CLK);
      chk("wr_b1_valid", tx_valid, 1);
      chk("wr_b1", tx_data, 16'h0005);
      @(negedge CLK);
      chk("wr_b2", tx_data, 16'h003C);
      @(negedge CLK);
      chk("wr_tx_done", tx_valid, 0);
      chk("wr_rsp_valid", rsp_valid, 1);
      chk("wr_rsp_data", rsp_data, 16'h0000);
      chk("wr_rsp_err", rsp_err, 0);
      @(negedge CLK);
      chk("wr_rsp_pulse", rsp_valid, 0);
      chk("wr_cmd_ready", cmd_ready, 1);

      // RD addr=2, response 0x7E after 20 cycles
      issue(0, 2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
      chk("rd_b0", tx_data, 16'h00BB);
      @(negedge CLK);
      chk("rd_b1", tx_data, 16'h0002);
      @(negedge CLK);
      chk("rd_tx_done", tx_valid, 0);
      chk("rd_wait_busy", busy, 1);
      seen = 1'b0;
      repeat (19) begin
         @(negedge CLK);
         if (rsp_valid) seen = 1'b1;
      end
      chk("rd_no_early_rsp", seen, 0);
      rx_valid = 1'b1; rx_data = 8'h7E;
      @(negedge CLK);
      rx_valid = 1'b0;
      chk("rd_rsp_valid", rsp_valid, 1);
      chk("rd_rsp_data", rsp_data, 16'h007E);
      chk("rd_rsp_err", rsp_err, 0);
      @(negedge CLK);
      chk("rd_rsp_hold", rsp_data, 16'h007E);

      // ALU op with TX_READY toggling; each byte must hold while stalled
      tx_ready = 1'b0;
      issue(0, 2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0);
      for (int i = 0; i < 4; i++) begin
         chk("alu_valid", tx_valid, 1);
         chk("alu_byte", tx_data, {8'h00, alu_bytes[i]});
         tx_ready = 1'b0;
         @(negedge CLK);
         chk("alu_byte_stall", tx_data, {8'h00, alu_bytes[i]});
         tx_ready = 1'b1;
         @(negedge CLK);
      end
      chk("alu_tx_done", tx_valid, 0);
      rx_valid = 1'b1; rx_data = 8'h46;
      @(negedge CLK);
      rx_valid = 1'b0;
      chk("alu_wait_hi", rsp_valid, 0);
      @(negedge CLK);
      rx_valid = 1'b1; rx_data = 8'h00;
      @(negedge CLK);
      rx_valid = 1'b0;
      chk("alu_rsp_valid", rsp_valid, 1);
      chk("alu_rsp_data", rsp_data, 16'h0046);
      chk("alu_rsp_err", rsp_err, 0);
      @(negedge CLK);

      // ALU nop fun=2, parity error on second response byte
      issue(0, 2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
      chk("nop_rsp_cleared", rsp_data, 16'h0000);
      chk("nop_b0", tx_data, 16'h00DD);
      @(negedge CLK);
      chk("nop_b1", tx_data, 16'h0002);
      @(negedge CLK);
      rx_valid = 1'b1; rx_data = 8'hF8;
      @(negedge CLK);
      rx_valid = 1'b0;
      @(negedge CLK);
      rx_valid = 1'b1; rx_data = 8'h00; rx_par = 1'b1;
      @(negedge CLK);
      rx_valid = 1'b0; rx_par = 1'b0;
      chk("nop_rsp_valid", rsp_valid, 1);
      chk("nop_rsp_err", rsp_err, 2'b10);
      chk("nop_rsp_lo", rsp_data[7:0], 16'h00F8);
      @(negedge CLK);

      // Timeout on the 16-cycle instance
      issue(1, 2'b01, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0);
      chk("to_b0", tx_data16, 16'h00BB);
      @(negedge CLK);
      chk("to_b1", tx_data16, 16'h0001);
      @(negedge CLK);
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (rsp_valid16) seen = 1'b1;
         @(negedge CLK);
      end
      chk("to_no_early", seen, 0);
      chk("to_rsp_valid", rsp_valid16, 1);
      chk("to_rsp_err", rsp_err16, 2'b01);
      chk("to_rsp_data", rsp_data16, 16'h0000);
      @(negedge CLK);
      chk("to_cmd_ready", cmd_ready16, 1);
      chk("to_rsp_pulse", rsp_valid16, 0);

      // Stray RX during SEND, then reset mid-frame
      tx_ready = 1'b1;
      issue(0, 2'b10, 4'h0, 8'h00, 8'hA1, 8'hB2, 4'h7);
      chk("mid_b0", tx_data, 16'h00CC);
      @(negedge CLK);
      tx_ready = 1'b0;
      rx_valid = 1'b1; rx_data = 8'h55;
      chk("mid_b1", tx_data, 16'h00A1);
      @(negedge CLK);
      rx_valid = 1'b0;
      chk("stray_tx_hold", tx_data, 16'h00A1);
      chk("stray_rsp_data", rsp_data, 16'h0000);
      chk("stray_no_rsp", rsp_valid, 0);
      #2 RST = 1'b0;
      #1;
      chk("arst_tx_valid", tx_valid, 0);
      chk("arst_tx_data", tx_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_cmd_ready", cmd_ready, 1);
      chk("arst_rsp", {rsp_valid, rsp_err, rsp_data[12:0]}, 0);
      @(negedge CLK);
      RST = 1'b1;
      tx_ready = 1'b1;
      @(negedge CLK);

      // RD after reset completes normally
      issue(0, 2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
      chk("post_b0", tx_data, 16'h00BB);
      @(negedge CLK);
      chk("post_b1", tx_data, 16'h0003);
      @(negedge CLK);
      rx_valid = 1'b1; rx_data = 8'h9A;
      @(negedge CLK);
      rx_valid = 1'b0;
      chk("post_rsp_valid", rsp_valid, 1);
      chk("post_rsp_data", rsp_data, 16'h009A);
      chk("post_rsp_err", rsp_err, 0);
      @(negedge CLK);
      chk("post_idle", cmd_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_master.md
Name: uart_cmd_master

Overview:
- Host-side initiator for the UART command protocol that the system controller decodes.
- Accepts one command per handshake and serializes it into the command byte stream: 0xAA write, 0xBB read, 0xCC ALU-with-operands, 0xDD ALU-no-operand. Bytes go out through a byte-wide TX handshake.
- Collects the 0, 1 or 2 response bytes from the UART receiver and returns them as one response word with error status.
- Used in the host-side test harness and the bridge toward the system's RX_IN/TX_OUT pins.

Parameters:
TIMEOUT_CYCLES, 4096, max CLK cycles allowed between entering a wait state or receiving a response byte and the next response byte
TO_W, 12, timeout counter width (ceil log2 TIMEOUT_CYCLES)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE; command accepted when CMD_VALID && CMD_READY
CMD_TYPE  in  2  00 write, 01 read, 10 ALU op, 11 ALU nop
CMD_ADDR  in  4  register address (WR/RD)
CMD_WDATA  in  8  write data (WR)
CMD_OPA  in  8  operand A (ALU op)
CMD_OPB  in  8  operand B (ALU op)
CMD_FUN  in  4  ALU function (ALU op/nop)
TX_DATA  out  8  byte to UART TX
TX_VALID  out  1  byte valid
TX_READY  in  1  UART TX can take byte
RX_DATA  in  8  byte from UART RX
RX_VALID  in  1  one-cycle strobe per received byte
RX_PAR_ERR  in  1  parity error on current RX byte
RX_FRM_ERR  in  1  framing error on current RX byte
RSP_DATA  out  16  response word
RSP_VALID  out  1  one-cycle completion pulse
RSP_ERR  out  2  bit0 timeout, bit1 RX error; valid with RSP_VALID
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. CMD_READY=1. TX_VALID=0, TX_DATA=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, BUSY=0. Byte index and timeout counter = 0.
- On accept, all command fields are latched. Inputs may change afterwards without effect.
- Frame contents, byte 0 first; only low nibble carries address/fun, upper nibble 0:
  - WR: AA, {0,ADDR}, WDATA (3 bytes).
  - RD: BB, {0,ADDR} (2 bytes).
  - ALU op: CC, OPA, OPB, {0,FUN} (4 bytes).
  - ALU nop: DD, {0,FUN} (2 bytes).
- Expected response bytes: WR 0, RD 1, ALU op/nop 2.
- States: IDLE, SEND, WAIT_LO, WAIT_HI, DONE.
- IDLE -> SEND on accept. TX_VALID rises in the cycle after accept.
- SEND:
  - TX_VALID=1; TX_DATA = frame[idx], held stable until transfer.
  - A transfer occurs on each edge with TX_VALID && TX_READY; idx then increments.
  - After the last byte transfers:
    - WR -> DONE.
    - Others -> WAIT_LO, with timeout counter cleared.
  - No TX_VALID gap between bytes when TX_READY stays high: one byte per cycle.
- WAIT_LO:
  - On RX_VALID with no error: RSP_DATA[7:0]=RX_DATA.
    - RD -> DONE.
    - ALU -> WAIT_HI, with counter cleared.
- WAIT_HI:
  - On RX_VALID with no error: RSP_DATA[15:8]=RX_DATA -> DONE.
- RD response: RSP_DATA[15:8]=0. WR response: RSP_DATA=0.
- Errors in WAIT_LO/WAIT_HI:
  - RX_VALID with RX_PAR_ERR or RX_FRM_ERR: set RSP_ERR[1], byte discarded, -> DONE. Bytes already captured are kept.
  - Counter reaching TIMEOUT_CYCLES-1 without RX_VALID: set RSP_ERR[0] -> DONE.
  - RX_VALID in the same cycle as the terminal count: the byte wins; no timeout.
- DONE: RSP_VALID=1 for exactly one cycle -> IDLE. RSP_DATA/RSP_ERR hold until the next accept, which clears them.
- RX_VALID in IDLE, SEND or DONE is ignored. Stray bytes must not corrupt a later response.
- RX errors in SEND/IDLE are ignored.
- Reset mid-operation: immediate return to IDLE. TX_VALID drops asynchronously; the partial frame is abandoned.
- Latency, RD with TX_READY constantly 1 and response byte arriving k cycles after the last TX transfer: RSP_VALID asserts k+1 cycles after that transfer.

Test Plan:
- WR addr=5 data=0x3C, TX_READY=1 -> TX bytes AA,05,3C on 3 consecutive cycles; RSP_VALID one pulse, RSP_DATA=0x0000, RSP_ERR=00.
- RD addr=2, RX returns 0x7E after 20 cycles -> TX BB,02; RSP_DATA=0x007E, RSP_ERR=00.
- ALU op A=0x12 B=0x34 fun=0, TX_READY toggling 1/0 -> TX CC,12,34,00 each held stable while stalled; RX 0x46 then 0x00 -> RSP_DATA=0x0046.
- ALU nop fun=2, RX sends 0xF8 then 0x00 with RX_PAR_ERR on the second -> RSP_ERR=10, RSP_DATA[7:0]=0xF8.
- RD with no RX byte (TIMEOUT_CYCLES=16) -> RSP_VALID exactly 16 cycles after WAIT_LO entry, RSP_ERR=01; CMD_READY=1 the next cycle.
- Stray RX_VALID 0x55 during SEND, then RST low during a 4-byte frame -> stray byte ignored; after reset all outputs return to reset values; a following RD completes normally.
